// File: rtl/sbox_share_arbiter_pkg.sv
// Shared AES definitions for the S-box arbiter: widths, owner tags and the
// forward substitution table.
package sbox_share_arbiter_pkg;

  localparam int STATE_W = 128;
  localparam int KX_W    = 32;

  // Owner tag carried with the operand stage
  localparam logic OWN_ST = 1'b0;
  localparam logic OWN_KX = 1'b1;

  // Operand stage contents
  typedef struct packed {
    logic               vld;
    logic               owner;
    logic [STATE_W-1:0] data;
  } op_stage_t;

  // Forward AES S-box, entry 0 first (leftmost)
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Single-byte substitution
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

endpackage

// File: rtl/sbox_share_arbiter_sbox.sv
// Combinational 128-bit S_BOX: every byte lane is substituted on its own.
module sbox_share_arbiter_sbox #(
  parameter int NUM_LANES = 16
) (
  input  logic [NUM_LANES-1:0][7:0] din,
  output logic [NUM_LANES-1:0][7:0] dout
);
  import sbox_share_arbiter_pkg::*;

  // One table lookup per byte lane
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign dout[i] = sbox_byte(din[i]);
  end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Shares one 128-bit S_BOX between the cipher-state path (SubBytes) and the
// key-expansion path (SubWord). One operand stage feeds the S_BOX; the result
// lands in the owner's response register one edge later.
module sbox_share_arbiter #(
  parameter bit KEY_PRIO = 1'b0,
  parameter int KX_W     = sbox_share_arbiter_pkg::KX_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    st_req_valid,
  output logic                                    st_req_ready,
  input  logic [sbox_share_arbiter_pkg::STATE_W-1:0] st_req_data,
  output logic                                    st_rsp_valid,
  input  logic                                    st_rsp_ready,
  output logic [sbox_share_arbiter_pkg::STATE_W-1:0] st_rsp_data,
  input  logic                                    kx_req_valid,
  output logic                                    kx_req_ready,
  input  logic [KX_W-1:0]                         kx_req_word,
  output logic                                    kx_rsp_valid,
  input  logic                                    kx_rsp_ready,
  output logic [KX_W-1:0]                         kx_rsp_word,
  output logic                                    busy
);
  import sbox_share_arbiter_pkg::*;

  op_stage_t          op;
  logic               last_grant;
  logic [STATE_W-1:0] sub_data;

  logic st_elig, kx_elig;
  logic st_first;
  logic st_rdy, kx_rdy;
  logic st_take, kx_take;

  // The one shared substitution instance, fed straight from the operand stage
  sbox_share_arbiter_sbox #(.NUM_LANES(STATE_W/8)) u_sbox (
    .din  (op.data),
    .dout (sub_data)
  );

  // Eligibility and grant. A requester is eligible when its operand is not in
  // flight and its response slot is empty or draining this cycle. Ready only
  // looks at the other side's valid, never its own.
  always_comb begin
    st_elig  = !(op.vld && op.owner == OWN_ST) && (!st_rsp_valid || st_rsp_ready);
    kx_elig  = !(op.vld && op.owner == OWN_KX) && (!kx_rsp_valid || kx_rsp_ready);
    st_first = (KEY_PRIO == 1'b0) && (last_grant == OWN_KX);
    st_rdy   = st_elig && !(kx_req_valid && kx_elig && !st_first);
    kx_rdy   = kx_elig && !(st_req_valid && st_elig &&  st_first);
  end

  // Readies are forced low while reset is held so every output reads 0
  assign st_req_ready = st_rdy && !rst;
  assign kx_req_ready = kx_rdy && !rst;
  assign st_take      = st_req_valid && st_req_ready;
  assign kx_take      = kx_req_valid && kx_req_ready;

  // Operand stage: load on accept, otherwise empties after one cycle in the S_BOX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op <= '0;
    end else if (st_take) begin
      op <= '{vld: 1'b1, owner: OWN_ST, data: st_req_data};
    end else if (kx_take) begin
      op <= '{vld: 1'b1, owner: OWN_KX,
              data: {{(STATE_W-KX_W){1'b0}}, kx_req_word}};
    end else begin
      op.vld <= 1'b0;
    end
  end

  // Round-robin history, moved only by an actual transfer.
  // Starts at KX so the state path wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_KX;
    end else if (st_take) begin
      last_grant <= OWN_ST;
    end else if (kx_take) begin
      last_grant <= OWN_KX;
    end
  end

  // State response register: capture S_BOX output for an ST operand, hold
  // until consumed. Eligibility guarantees the slot is free when it fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_rsp_valid <= 1'b0;
      st_rsp_data  <= '0;
    end else if (op.vld && op.owner == OWN_ST) begin
      st_rsp_valid <= 1'b1;
      st_rsp_data  <= sub_data;
    end else if (st_rsp_ready) begin
      st_rsp_valid <= 1'b0;
    end
  end

  // Key response register: only the low word of the S_BOX output matters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx_rsp_valid <= 1'b0;
      kx_rsp_word  <= '0;
    end else if (op.vld && op.owner == OWN_KX) begin
      kx_rsp_valid <= 1'b1;
      kx_rsp_word  <= sub_data[KX_W-1:0];
    end else if (kx_rsp_ready) begin
      kx_rsp_valid <= 1'b0;
    end
  end

  assign busy = op.vld | st_rsp_valid | kx_rsp_valid;

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Bench for sbox_share_arbiter: two instances (round-robin and key-priority),
// directed scenarios plus randomized traffic against a transaction model.
module tb_sbox_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         st_req_valid[2], st_req_ready[2], st_rsp_valid[2], st_rsp_ready[2];
  logic         kx_req_valid[2], kx_req_ready[2], kx_rsp_valid[2], kx_rsp_ready[2];
  logic         busy[2];
  logic [127:0] st_req_data[2], st_rsp_data[2];
  logic [31:0]  kx_req_word[2], kx_rsp_word[2];

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: round-robin, instance 1: key path wins conflicts
  for (genvar k = 0; k < 2; k++) begin : g_dut
    sbox_share_arbiter #(.KEY_PRIO(k == 1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .st_req_valid (st_req_valid[k]),
      .st_req_ready (st_req_ready[k]),
      .st_req_data  (st_req_data[k]),
      .st_rsp_valid (st_rsp_valid[k]),
      .st_rsp_ready (st_rsp_ready[k]),
      .st_rsp_data  (st_rsp_data[k]),
      .kx_req_valid (kx_req_valid[k]),
      .kx_req_ready (kx_req_ready[k]),
      .kx_req_word  (kx_req_word[k]),
      .kx_rsp_valid (kx_rsp_valid[k]),
      .kx_rsp_ready (kx_rsp_ready[k]),
      .kx_rsp_word  (kx_rsp_word[k]),
      .busy         (busy[k])
    );
  end

  // Reference S-box built from GF(2^8) inversion plus the affine map
  logic [7:0] sref[256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sref[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      st_req_valid[k] = 1'b0; st_req_data[k] = '0; st_rsp_ready[k] = 1'b0;
      kx_req_valid[k] = 1'b0; kx_req_word[k] = '0; kx_rsp_ready[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({st_req_ready[k], kx_req_ready[k], st_rsp_valid[k], kx_rsp_valid[k], busy[k],
           st_rsp_data[k], kx_rsp_word[k]} !== '0) begin
        miscompares++;
        $display("FAIL reset dut%0d: outputs not all zero (st_rdy=%b kx_rdy=%b busy=%b)",
                 k, st_req_ready[k], kx_req_ready[k], busy[k]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_st_only();
    logic [127:0] exp_d = 128'hd42711aee0bf98f1b8b45de51e415230;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      st_req_valid[k] = 1'b1; st_req_data[k] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      st_rsp_ready[k] = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        case (c)
          0: if (st_req_ready[k] !== 1'b1) begin
               miscompares++; $display("FAIL st_only accept dut%0d: got %b want 1", k, st_req_ready[k]);
             end
          1: if ({st_rsp_valid[k], busy[k]} !== 2'b01) begin
               miscompares++; $display("FAIL st_only inflight dut%0d: rsp_v/busy got %b want 01",
                                       k, {st_rsp_valid[k], busy[k]});
             end
          2: if (st_rsp_valid[k] !== 1'b1 || st_rsp_data[k] !== exp_d) begin
               miscompares++; $display("FAIL st_only result dut%0d: v=%b got %h want %h",
                                       k, st_rsp_valid[k], st_rsp_data[k], exp_d);
             end
          default: if ({st_rsp_valid[k], busy[k]} !== 2'b00) begin
               miscompares++; $display("FAIL st_only drain dut%0d: rsp_v/busy got %b want 00",
                                       k, {st_rsp_valid[k], busy[k]});
             end
        endcase
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) st_req_valid[k] = 1'b0;
    end
  endtask

  task automatic test_kx_only();
    logic [31:0] win[3]  = '{32'hcf4f3c09, 32'h00530001, 32'hffffffff};
    logic [31:0] wout[3] = '{32'h8a84eb01, 32'h63ed637c, 32'h16161616};
    do_reset();
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 2; k++) begin
        kx_req_valid[k] = 1'b1; kx_req_word[k] = win[v]; kx_rsp_ready[k] = 1'b1;
      end
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          if (c == 0) begin
            vectors++;
            if (kx_req_ready[k] !== 1'b1) begin
              miscompares++; $display("FAIL kx_only accept dut%0d v%0d: got %b want 1", k, v, kx_req_ready[k]);
            end
          end else if (c == 2) begin
            vectors++;
            if (kx_rsp_valid[k] !== 1'b1 || kx_rsp_word[k] !== wout[v]) begin
              miscompares++; $display("FAIL kx_only result dut%0d: v=%b got %h want %h",
                                      k, kx_rsp_valid[k], kx_rsp_word[k], wout[v]);
            end
          end else if (c == 3) begin
            vectors++;
            if (busy[k] !== 1'b0) begin
              miscompares++; $display("FAIL kx_only drain dut%0d: busy got %b want 0", k, busy[k]);
            end
          end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) kx_req_valid[k] = 1'b0;
      end
    end
  endtask

  // Both requesters always valid: accepts alternate one per cycle
  task automatic test_conflict();
    logic [127:0] exp_s[2];
    logic [31:0]  exp_k[2];
    logic         tk_s[2], tk_k[2];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      st_req_valid[k] = 1'b1; st_req_data[k] = rnd128(); st_rsp_ready[k] = 1'b1;
      kx_req_valid[k] = 1'b1; kx_req_word[k] = $urandom(); kx_rsp_ready[k] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic want_st;
        want_st = (k == 0) ? (c % 2 == 0) : (c % 2 == 1);
        vectors++;
        if ({st_req_ready[k], kx_req_ready[k]} !== {want_st, !want_st}) begin
          miscompares++; $display("FAIL conflict grant dut%0d c%0d: st/kx ready got %b want %b",
                                  k, c, {st_req_ready[k], kx_req_ready[k]}, {want_st, !want_st});
        end
        if (c >= 2) begin
          vectors++;
          if ({st_rsp_valid[k], kx_rsp_valid[k]} !== {want_st, !want_st} ||
              (want_st && st_rsp_data[k] !== exp_s[k]) ||
              (!want_st && kx_rsp_word[k] !== exp_k[k])) begin
            miscompares++; $display("FAIL conflict result dut%0d c%0d: v=%b st=%h/%h kx=%h/%h", k, c,
                                    {st_rsp_valid[k], kx_rsp_valid[k]}, st_rsp_data[k], exp_s[k],
                                    kx_rsp_word[k], exp_k[k]);
          end
        end
        tk_s[k] = want_st; tk_k[k] = !want_st;
        if (want_st) exp_s[k] = sub128(st_req_data[k]);
        else         exp_k[k] = sub128({96'h0, kx_req_word[k]})[31:0];
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (tk_s[k]) st_req_data[k] = rnd128();
        if (tk_k[k]) kx_req_word[k] = $urandom();
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [127:0] d0 = rnd128();
    logic [127:0] d1 = rnd128();
    do_reset();
    for (int k = 0; k < 2; k++) begin st_req_valid[k] = 1'b1; st_req_data[k] = d0; end
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) st_rsp_ready[k] = (c >= 7);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (c == 0 && st_req_ready[k] !== 1'b1) begin
          miscompares++; $display("FAIL bp first_accept dut%0d: got %b want 1", k, st_req_ready[k]);
        end else if (c >= 1 && c <= 6 && st_req_ready[k] !== 1'b0) begin
          miscompares++; $display("FAIL bp stall dut%0d c%0d: st_req_ready got %b want 0", k, c, st_req_ready[k]);
        end else if (c >= 2 && c <= 6 && (st_rsp_valid[k] !== 1'b1 || st_rsp_data[k] !== sub128(d0))) begin
          miscompares++; $display("FAIL bp hold dut%0d c%0d: v=%b got %h want %h",
                                  k, c, st_rsp_valid[k], st_rsp_data[k], sub128(d0));
        end else if (c == 7 && {st_req_ready[k], st_rsp_valid[k]} !== 2'b11) begin
          miscompares++; $display("FAIL bp pop_accept dut%0d: rdy/v got %b want 11",
                                  k, {st_req_ready[k], st_rsp_valid[k]});
        end else if (c == 8 && {st_rsp_valid[k], busy[k]} !== 2'b01) begin
          miscompares++; $display("FAIL bp gap dut%0d: v/busy got %b want 01", k, {st_rsp_valid[k], busy[k]});
        end else if (c == 9 && (st_rsp_valid[k] !== 1'b1 || st_rsp_data[k] !== sub128(d1))) begin
          miscompares++; $display("FAIL bp second dut%0d: v=%b got %h want %h",
                                  k, st_rsp_valid[k], st_rsp_data[k], sub128(d1));
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (c == 0) st_req_data[k] = d1;
        if (c == 7) st_req_valid[k] = 1'b0;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 2; k++) begin kx_req_valid[k] = 1'b1; kx_req_word[k] = $urandom(); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (c == 0 || c == 2) begin
          vectors++;
          if ((c == 0 && kx_req_ready[k] !== 1'b1) ||
              (c == 2 && {st_req_ready[k], kx_rsp_valid[k]} !== 2'b11)) begin
            miscompares++; $display("FAIL rstmid setup dut%0d c%0d: kx_rdy=%b st_rdy=%b kx_v=%b",
                                    k, c, kx_req_ready[k], st_req_ready[k], kx_rsp_valid[k]);
          end
        end else if (c == 3) begin
          vectors++;
          if ({busy[k], kx_rsp_valid[k]} !== 2'b11) begin
            miscompares++; $display("FAIL rstmid inflight dut%0d: busy/kx_v got %b want 11",
                                    k, {busy[k], kx_rsp_valid[k]});
          end
        end
      end
      if (c == 3) break;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        kx_req_valid[k] = 1'b0;
        st_req_valid[k] = (c == 1);
        st_req_data[k]  = rnd128();
      end
    end
    for (int k = 0; k < 2; k++) st_req_valid[k] = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({st_req_ready[k], kx_req_ready[k], st_rsp_valid[k], kx_rsp_valid[k], busy[k],
           st_rsp_data[k], kx_rsp_word[k]} !== '0) begin
        miscompares++; $display("FAIL rstmid async dut%0d: busy=%b kx_v=%b st_v=%b",
                                k, busy[k], kx_rsp_valid[k], st_rsp_valid[k]);
      end
      st_req_valid[k] = 1'b1; kx_req_valid[k] = 1'b1;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({st_req_ready[k], kx_req_ready[k]} !== ((k == 0) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL rstmid first_grant dut%0d: st/kx ready got %b want %b",
                                k, {st_req_ready[k], kx_req_ready[k]}, (k == 0) ? 2'b10 : 2'b01);
      end
    end
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Random traffic. The model tracks, per requester, whether an operation is
  // in the S_BOX this cycle and whether a result is waiting, plus who won last.
  task automatic test_random();
    logic inop_s[2], inop_k[2], held_s[2], held_k[2], lastk[2], acc_s[2], acc_k[2];
    logic [127:0] op_s[2], rsp_s[2];
    logic [31:0]  op_k[2], rsp_k[2];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      inop_s[k] = 0; inop_k[k] = 0; held_s[k] = 0; held_k[k] = 0; lastk[k] = 1;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!st_req_valid[k] && $urandom_range(0, 2) != 0) begin
          st_req_valid[k] = 1'b1; st_req_data[k] = rnd128();
        end
        if (!kx_req_valid[k] && $urandom_range(0, 2) != 0) begin
          kx_req_valid[k] = 1'b1; kx_req_word[k] = $urandom();
        end
        st_rsp_ready[k] = ($urandom_range(0, 3) != 0);
        kx_rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic el_s, el_k, want_s, want_k, st_first, er_s, er_k, eb;
        el_s = !inop_s[k] && (!held_s[k] || st_rsp_ready[k]);
        el_k = !inop_k[k] && (!held_k[k] || kx_rsp_ready[k]);
        want_s = st_req_valid[k] && el_s;
        want_k = kx_req_valid[k] && el_k;
        st_first = (k == 0) && lastk[k];
        er_s = el_s && !(want_k && !st_first);
        er_k = el_k && !(want_s && st_first);
        eb = inop_s[k] || inop_k[k] || held_s[k] || held_k[k];
        vectors++;
        if ({st_req_ready[k], kx_req_ready[k], st_rsp_valid[k], kx_rsp_valid[k], busy[k]} !==
            {er_s, er_k, held_s[k], held_k[k], eb}) begin
          miscompares++; $display("FAIL random ctrl dut%0d c%0d: rdy/rdy/v/v/busy got %b want %b", k, c,
                                  {st_req_ready[k], kx_req_ready[k], st_rsp_valid[k], kx_rsp_valid[k], busy[k]},
                                  {er_s, er_k, held_s[k], held_k[k], eb});
        end
        if (held_s[k]) begin
          vectors++;
          if (st_rsp_data[k] !== rsp_s[k]) begin
            miscompares++; $display("FAIL random st_data dut%0d c%0d: got %h want %h", k, c, st_rsp_data[k], rsp_s[k]);
          end
        end
        if (held_k[k]) begin
          vectors++;
          if (kx_rsp_word[k] !== rsp_k[k]) begin
            miscompares++; $display("FAIL random kx_word dut%0d c%0d: got %h want %h", k, c, kx_rsp_word[k], rsp_k[k]);
          end
        end
        acc_s[k] = st_req_valid[k] && er_s;
        acc_k[k] = kx_req_valid[k] && er_k;
        if (acc_s[k] || acc_k[k]) lastk[k] = acc_k[k];
        held_s[k] = inop_s[k] || (held_s[k] && !st_rsp_ready[k]);
        held_k[k] = inop_k[k] || (held_k[k] && !kx_rsp_ready[k]);
        if (inop_s[k]) rsp_s[k] = op_s[k];
        if (inop_k[k]) rsp_k[k] = op_k[k];
        inop_s[k] = acc_s[k];
        inop_k[k] = acc_k[k];
        if (acc_s[k]) op_s[k] = sub128(st_req_data[k]);
        if (acc_k[k]) op_k[k] = sub128({96'h0, kx_req_word[k]})[31:0];
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (acc_s[k]) st_req_valid[k] = 1'b0;
        if (acc_k[k]) kx_req_valid[k] = 1'b0;
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sref[i] = sbox_ref(8'(i));
    test_reset();
    test_st_only();
    test_kx_only();
    test_conflict();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
- Shares one 128-bit S_BOX substitution instance between two requesters: the cipher round path (state SubBytes, 128 bit) and the key-expansion path (SubWord, 32 bit).
- Arbitrates requests with valid/ready handshakes and registers the operand in an operand stage.
- Returns each result through a per-requester response register with valid/ready.
- Sits between the round controller/key scheduler and the substitution datapath, so the design needs one S_BOX instance instead of two.

Parameters:
- KEY_PRIO, 0: 0 = round-robin between requesters; 1 = key-expansion requester always wins a conflict.
- KX_W, 32: key-expansion word width. Fixed at 32 and must not be changed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_req_valid  in  1  cipher-state lookup request.
- st_req_ready  out  1  request accepted this cycle when high together with st_req_valid.
- st_req_data  in  128  state to substitute.
- st_rsp_valid  out  1  state result available.
- st_rsp_ready  in  1  consumer takes the result.
- st_rsp_data  out  128  substituted state.
- kx_req_valid  in  1  key-word lookup request.
- kx_req_ready  out  1  key request accepted.
- kx_req_word  in  32  word to substitute.
- kx_rsp_valid  out  1  key result available.
- kx_rsp_ready  in  1  consumer takes the key result.
- kx_rsp_word  out  32  substituted word.
- busy  out  1  high while the operand stage or either response register holds data.

Behaviour:
- Reset: all outputs 0. Operand stage and both response registers are invalid. last_grant = KX, so ST wins the first conflict in round-robin mode. Reset is asynchronous and may arrive mid-operation; in-flight and held results are discarded.
- Handshake: a transfer occurs when valid && ready are high on the same rising edge.
  - Requesters hold valid and data stable until accepted.
  - rsp_valid/rsp_data stay stable until rsp_ready.
  - ready never depends on the same requester's own valid, but may depend on the other requester's valid.
- Eligibility of requester X: its own operand is not in the operand stage, AND (X_rsp_valid == 0 OR X_rsp_ready == 1 this cycle). At most one outstanding operation per requester.
- Arbitration, combinational, one grant per cycle:
  - Only one requester eligible and valid: it gets ready.
  - Both eligible and valid: KEY_PRIO=1 grants KX. KEY_PRIO=0 grants the requester that is not last_grant.
  - last_grant updates only on an accepted transfer.
- Operand stage (op_valid, op_owner, op_data[127:0]) is loaded on accept.
  - ST request: op_data = st_req_data.
  - KX request: op_data = {96'h0, kx_req_word}.
- S_BOX sees op_data combinationally. On the following edge, the S_BOX output is written into the owner's response register, and op_valid clears unless a new accept occurs the same cycle.
  - ST response: st_rsp_data = full 128 bits.
  - KX response: kx_rsp_word = bits [31:0].
- Latency: accept at edge N, response valid after edge N+1, i.e. visible in cycle N+2.
- Throughput:
  - Single requester with rsp_ready held high: one accept every 2 cycles.
  - Alternating requesters: one accept every cycle.
- Simultaneous events:
  - A response pop and the same requester's accept in one cycle are legal; the new result arrives two edges later.
  - Both responses may pop in the same cycle.
- busy = op_valid | st_rsp_valid | kx_rsp_valid.
- Byte mapping is unchanged from S_BOX: each byte [8i+7:8i] is substituted independently.

Decomposition:
- Shared aes package:
  - owner encoding constants OWN_ST=1'b0, OWN_KX=1'b1;
  - STATE_W=128;
  - KX_W=32.
- One sub-module: the existing S_BOX, instantiated once on op_data. No new sub-modules.

Test Plan:
1. ST only:
   - Stimulus: st_req_data=128'h193de3bea0f4e22b9ac68d2ae9f84808, st_rsp_ready=1.
   - Response: st_rsp_valid in cycle N+2 with 128'hd42711aee0bf98f1b8b45de51e415230; busy returns to 0 the cycle after the pop.
2. KX only:
   - Stimulus: kx_req_word=32'hcf4f3c09.
   - Response: kx_rsp_word=32'h8a84eb01. Byte checks: 32'h00530001 -> 32'h63ed637c, and 32'hffffffff -> 32'h16161616.
3. Conflict, KEY_PRIO=0:
   - Stimulus: both requesters valid, continuously, from reset.
   - Response: grants alternate ST, KX, ST, KX. Each result is correct and tagged to the right owner; one accept per cycle.
4. Conflict, KEY_PRIO=1:
   - Stimulus: both requesters valid.
   - Response: KX is accepted first; ST is accepted the next cycle because KX is then ineligible.
5. Backpressure:
   - Stimulus: st_rsp_ready=0 for 5 cycles after the first ST result.
   - Response: st_rsp_data stays stable and st_req_ready stays 0. When ready rises, pop and re-accept happen in the same cycle.
6. Reset mid-operation:
   - Stimulus: assert rst while op_valid=1 and kx_rsp_valid=1.
   - Response: all outputs go to 0 immediately, with no clock edge needed. After release, the first conflict is granted to ST.
